controlador_barrido_display: RTL and testbench

CONTROLADOR_BARRIDO_DISPLAY -- requirements
Module: controlador_barrido_display

---
 rtl/controlador_barrido_display.sv | 128 ++++++++++++
 tb/tb_controlador_barrido_display.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_barrido_display.sv
// Four-digit multiplexed 7-segment scan controller with a background binary-to-BCD
// (double-dabble) converter that refreshes the shown value once per scan frame.
module controlador_barrido_display #(
    parameter int DIV_REFRESCO = 100000,
    parameter bit BLANK_CEROS  = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       control,
    input  logic [7:0] frecuencia,
    input  logic [9:0] corriente,
    output logic [3:0] selec_digito,
    output logic [3:0] digito,
    output logic       ocupado
);

    localparam int CW = $clog2(DIV_REFRESCO);

    typedef enum logic [1:0] {REPOSO, CAPTURA, CONVIERTE, CARGA} estado_t;

    logic [CW-1:0]   contador;
    logic [1:0]      indice;
    logic            fin_slot;
    logic            vuelta;

    estado_t         estado, estado_sig;
    logic [3:0]      iteracion;
    logic [9:0]      desplaza;
    logic [15:0]     bcd, bcd_ajustado;
    logic [3:0][3:0] pantalla, pantalla_nueva;
    logic            captura_en, convierte_en, carga_en;

    assign fin_slot = (contador == CW'(DIV_REFRESCO - 1));
    assign vuelta   = fin_slot && (indice == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            contador <= '0;
            indice   <= 2'd0;
        end else if (fin_slot) begin
            contador <= '0;
            indice   <= indice + 2'd1;
        end else begin
            contador <= contador + 1'b1;
        end
    end

    // Outputs lag the counter by one cycle, so the edge after reset release emits slot 0's guard.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            selec_digito <= 4'b1111;
            digito       <= 4'hF;
        end else if (contador == '0) begin
            selec_digito <= 4'b1111;
            digito       <= pantalla[indice];
        end else begin
            selec_digito <= ~(4'b0001 << indice);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= REPOSO;
        else          estado <= estado_sig;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:    if (vuelta) estado_sig = CAPTURA;
            CAPTURA:   estado_sig = CONVIERTE;
            CONVIERTE: if (iteracion == 4'd9) estado_sig = CARGA;
            CARGA:     estado_sig = REPOSO;
            default:   estado_sig = REPOSO;
        endcase
    end

    always_comb begin
        ocupado      = (estado != REPOSO);
        captura_en   = (estado == CAPTURA);
        convierte_en = (estado == CONVIERTE);
        carga_en     = (estado == CARGA);
    end

    always_comb begin
        bcd_ajustado = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[4*n +: 4] >= 4'd5) bcd_ajustado[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
        end
    end

    // Blanking cascades from millares down; unidades always shows its digit.
    always_comb begin
        pantalla_nueva = bcd;
        if (BLANK_CEROS) begin
            if (bcd[15:12] == 4'd0) begin
                pantalla_nueva[3] = 4'hF;
                if (bcd[11:8] == 4'd0) begin
                    pantalla_nueva[2] = 4'hF;
                    if (bcd[7:4] == 4'd0) pantalla_nueva[1] = 4'hF;
                end
            end
        end
    end

    // NOTE: the small display register is reset explicitly so the first frame shows "0", not garbage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            desplaza  <= '0;
            bcd       <= '0;
            iteracion <= 4'd0;
            pantalla  <= {4'hF, 4'hF, 4'hF, 4'h0};
        end else begin
            if (captura_en) begin
                desplaza  <= control ? {2'b00, frecuencia} : corriente;
                bcd       <= '0;
                iteracion <= 4'd0;
            end
            if (convierte_en) begin
                {bcd, desplaza} <= {bcd_ajustado, desplaza} << 1;
                iteracion       <= iteracion + 4'd1;
            end
            if (carga_en) pantalla <= pantalla_nueva;
        end
    end

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Directed bench for the scan controller: two instances (leading-zero blanking on/off)
// share stimulus; frames are sampled relative to the rising edge of ocupado.
module tb_controlador_barrido_display;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       control;
    logic [7:0] frecuencia;
    logic [9:0] corriente;
    logic [3:0] selec_digito, digito, selec_nb, digito_nb;
    logic       ocupado, ocupado_nb;

    int checks   = 0;
    int failures = 0;
    logic [3:0] sel_prev = 4'hF;

    always #5 clock = ~clock;

    controlador_barrido_display #(.DIV_REFRESCO(16), .BLANK_CEROS(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .control(control), .frecuencia(frecuencia),
        .corriente(corriente), .selec_digito(selec_digito), .digito(digito), .ocupado(ocupado)
    );

    controlador_barrido_display #(.DIV_REFRESCO(16), .BLANK_CEROS(1'b0)) dut_nb (
        .clock(clock), .reset_n(reset_n), .control(control), .frecuencia(frecuencia),
        .corriente(corriente), .selec_digito(selec_nb), .digito(digito_nb), .ocupado(ocupado_nb)
    );

    // Every cycle: at most one enabled anode, and no direct enable-to-enable switch.
    always @(negedge clock) begin
        if (!reset_n) begin
            sel_prev = 4'hF;
        end else begin
            checks++;
            if ($countones(~selec_digito) > 1) begin
                failures++;
                $display("FAIL onehot selec_digito=%b required at most one zero", selec_digito);
            end
            if (sel_prev != 4'hF && selec_digito != 4'hF && selec_digito != sel_prev) begin
                failures++;
                $display("FAIL guard selec_digito=%b after %b required 1111 in between", selec_digito, sel_prev);
            end
            sel_prev = selec_digito;
        end
    end

    task automatic wait_capture();
        logic prev;
        bit   ok;
        prev = ocupado;
        ok   = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            if (ocupado === 1'b1 && prev === 1'b0) ok = 1'b1;
            prev = ocupado;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL capture_timeout ocupado=%b required rising edge within 200 cycles", ocupado);
        end
    endtask

    // k=0 is the CAPTURA cycle; slot s guard at k=1+16s, enabled from k=2+16s.
    task automatic read_frame(input int change_k, input logic [9:0] nuevo,
                              output logic [15:0] f1, output logic [15:0] f0);
        f1 = 'x;
        f0 = 'x;
        wait_capture();
        for (int k = 1; k <= 63; k++) begin
            @(negedge clock);
            if (k == change_k) corriente = nuevo;
            for (int s = 0; s < 4; s++) begin
                if (k == 2 + 16 * s) begin
                    f1[4*s +: 4] = digito;
                    f0[4*s +: 4] = digito_nb;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel, exp_dig;
        reset_n    = 1'b0;
        control    = 1'b0;
        frecuencia = 8'd0;
        corriente  = 10'd0;
        repeat (3) @(negedge clock);
        checks++;
        if (selec_digito !== 4'b1111 || digito !== 4'hF || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs sel=%b dig=%h ocu=%b required 1111 f 0", selec_digito, digito, ocupado);
        end
        checks++;
        if (selec_nb !== 4'b1111 || digito_nb !== 4'hF || ocupado_nb !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs_nb sel=%b dig=%h ocu=%b required 1111 f 0", selec_nb, digito_nb, ocupado_nb);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            if (k == 1 || k == 17 || k == 33) exp_sel = 4'b1111;
            else if (k <= 16)                 exp_sel = 4'b1110;
            else if (k <= 32)                 exp_sel = 4'b1101;
            else                              exp_sel = 4'b1011;
            exp_dig = (k <= 16) ? 4'h0 : 4'hF;
            checks++;
            if (selec_digito !== exp_sel || digito !== exp_dig) begin
                failures++;
                $display("FAIL scan_k%0d sel=%b dig=%h required %b %h", k, selec_digito, digito, exp_sel, exp_dig);
            end
        end
    endtask

    task automatic test_frecuencia();
        int n;
        logic [15:0] f1, f0;
        control    = 1'b1;
        frecuencia = 8'd255;
        wait_capture();
        n = 1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (ocupado === 1'b1) n++;
            else break;
        end
        checks++;
        if (n != 12) begin
            failures++;
            $display("FAIL ocupado_len cycles=%0d required 12", n);
        end
        read_frame(-1, 10'd0, f1, f0);
        checks++;
        if (f1 !== 16'hF255) begin
            failures++;
            $display("FAIL frec255 got=%h required f255", f1);
        end
        checks++;
        if (f0 !== 16'h0255) begin
            failures++;
            $display("FAIL frec255_nb got=%h required 0255", f0);
        end
    endtask

    task automatic test_corriente();
        logic [9:0]  vals [6] = '{10'd0, 10'd7, 10'd10, 10'd105, 10'd1000, 10'd1023};
        logic [15:0] exp1 [6] = '{16'hFFF0, 16'hFFF7, 16'hFF10, 16'hF105, 16'h1000, 16'h1023};
        logic [15:0] exp0 [6] = '{16'h0000, 16'h0007, 16'h0010, 16'h0105, 16'h1000, 16'h1023};
        logic [15:0] f1, f0;
        control = 1'b0;
        for (int i = 0; i < 6; i++) begin
            corriente = vals[i];
            read_frame(-1, 10'd0, f1, f0);
            read_frame(-1, 10'd0, f1, f0);
            checks++;
            if (f1 !== exp1[i]) begin
                failures++;
                $display("FAIL corriente_%0d got=%h required %h", vals[i], f1, exp1[i]);
            end
            checks++;
            if (f0 !== exp0[i]) begin
                failures++;
                $display("FAIL corriente_nb_%0d got=%h required %h", vals[i], f0, exp0[i]);
            end
        end
    endtask

    task automatic test_cambio();
        logic [15:0] f1, f0;
        control   = 1'b0;
        corriente = 10'd100;
        read_frame(-1, 10'd0, f1, f0);
        read_frame(3, 10'd999, f1, f0);
        checks++;
        if (f1 !== 16'hF100) begin
            failures++;
            $display("FAIL cambio_actual got=%h required f100", f1);
        end
        // Unidades of this frame is read before the 999 conversion loads.
        read_frame(-1, 10'd0, f1, f0);
        checks++;
        if (f1 !== 16'hF990) begin
            failures++;
            $display("FAIL cambio_transicion got=%h required f990", f1);
        end
        read_frame(-1, 10'd0, f1, f0);
        checks++;
        if (f1 !== 16'hF999) begin
            failures++;
            $display("FAIL cambio_siguiente got=%h required f999", f1);
        end
    endtask

    task automatic test_reset_mid();
        control   = 1'b0;
        corriente = 10'd1023;
        wait_capture();
        repeat (4) @(negedge clock);
        checks++;
        if (ocupado !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy ocupado=%b required 1", ocupado);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (selec_digito !== 4'b1111 || digito !== 4'hF || ocupado !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset sel=%b dig=%h ocu=%b required 1111 f 0", selec_digito, digito, ocupado);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 1) begin
                checks++;
                if (selec_digito !== 4'b1111 || digito !== 4'h0 || ocupado !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_restart sel=%b dig=%h ocu=%b required 1111 0 0", selec_digito, digito, ocupado);
                end
            end
            if (k == 17) begin
                checks++;
                if (digito !== 4'hF) begin
                    failures++;
                    $display("FAIL mid_decenas dig=%h required f", digito);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frecuencia();
        test_corriente();
        test_cambio();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
